// File: rtl/axis_upsizer.sv
// AXI4-Stream width upsizer: packs RATIO narrow beats into one wide beat.
// A level-sensitive flush emits a partially filled, zero-padded word with its lane count.
module axis_upsizer #(
  parameter  int IN_WIDTH  = 8,
  parameter  int RATIO     = 4,
  localparam int OUT_WIDTH = IN_WIDTH * RATIO,
  localparam int CNT_W     = $clog2(RATIO) + 1
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  input  logic                 s_tvalid,
  output logic                 s_tready,
  input  logic [IN_WIDTH-1:0]  s_tdata,
  output logic                 m_tvalid,
  input  logic                 m_tready,
  output logic [OUT_WIDTH-1:0] m_tdata,
  output logic [CNT_W-1:0]     m_tcnt,
  input  logic                 flush,
  output logic                 pending
);

  localparam int              IDX_W = $clog2(RATIO);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(RATIO - 1);

  logic [OUT_WIDTH-1:0] acc;
  logic [OUT_WIDTH-1:0] acc_nxt;
  logic [IDX_W-1:0]     idx;
  logic [OUT_WIDTH-1:0] out_data;
  logic [CNT_W-1:0]     out_cnt;
  logic                 out_valid;

  logic                 out_free;
  logic                 s_hs;
  logic                 m_hs;
  logic                 complete;
  logic                 flush_fire;
  logic                 load;
  logic [CNT_W-1:0]     n;

  assign out_free = !out_valid || m_tready;
  // The last lane may only be accepted when the output register can take the word.
  assign s_tready = aresetn && ((idx != LAST) || out_free);
  assign s_hs     = s_tvalid && s_tready;
  assign m_hs     = out_valid && m_tready;

  assign n          = {1'b0, idx} + CNT_W'(s_hs);
  assign complete   = s_hs && (idx == LAST);
  assign flush_fire = flush && !complete && (n != '0) && out_free;
  assign load       = complete || flush_fire;

  // Lanes above idx are always zero because acc is cleared on every emission.
  always_comb begin
    acc_nxt = acc;
    if (s_hs)
      acc_nxt[idx*IN_WIDTH +: IN_WIDTH] = s_tdata;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      acc       <= '0;
      idx       <= '0;
      out_data  <= '0;
      out_cnt   <= '0;
      out_valid <= 1'b0;
    end else if (load) begin
      out_data  <= acc_nxt;
      out_cnt   <= n;
      out_valid <= 1'b1;
      acc       <= '0;
      idx       <= '0;
    end else begin
      if (m_hs)
        out_valid <= 1'b0;
      if (s_hs) begin
        acc <= acc_nxt;
        idx <= idx + 1'b1;
      end
    end
  end

  assign m_tvalid = out_valid;
  assign m_tdata  = out_data;
  assign m_tcnt   = out_cnt;
  assign pending  = (idx != '0);

endmodule

// File: tb/tb_axis_upsizer.sv
// Scoreboard bench for axis_upsizer: expected wide words are queued as narrow
// beats are driven and compared when the DUT hands each one off.
module tb_axis_upsizer;

  localparam int IN_WIDTH  = 8;
  localparam int RATIO     = 4;
  localparam int OUT_WIDTH = IN_WIDTH * RATIO;
  localparam int CNT_W     = $clog2(RATIO) + 1;

  logic                 aclk = 1'b0;
  logic                 aresetn;
  logic                 s_tvalid;
  logic                 s_tready;
  logic [IN_WIDTH-1:0]  s_tdata;
  logic                 m_tvalid;
  logic                 m_tready;
  logic [OUT_WIDTH-1:0] m_tdata;
  logic [CNT_W-1:0]     m_tcnt;
  logic                 flush;
  logic                 pending;

  typedef struct packed {
    logic [OUT_WIDTH-1:0] data;
    logic [CNT_W-1:0]     cnt;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_err = 0;
  int   w;

  axis_upsizer #(.IN_WIDTH(IN_WIDTH), .RATIO(RATIO)) dut (
    .aclk     (aclk),
    .aresetn  (aresetn),
    .s_tvalid (s_tvalid),
    .s_tready (s_tready),
    .s_tdata  (s_tdata),
    .m_tvalid (m_tvalid),
    .m_tready (m_tready),
    .m_tdata  (m_tdata),
    .m_tcnt   (m_tcnt),
    .flush    (flush),
    .pending  (pending)
  );

  always #5 aclk = ~aclk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic push_exp(input logic [OUT_WIDTH-1:0] d, input logic [CNT_W-1:0] c);
    exp_t e;
    e.data = d;
    e.cnt  = c;
    sb.push_back(e);
  endtask

  // Called just after a rising edge; returns just after the edge that accepted the beat.
  task automatic send(input logic [IN_WIDTH-1:0] d, output int waits);
    s_tvalid = 1'b1;
    s_tdata  = d;
    waits    = 0;
    while (1) begin
      @(negedge aclk);
      if (s_tready) break;
      waits++;
      if (waits > 50) begin
        chk("send_timeout", 64'(waits), 0);
        break;
      end
    end
    @(posedge aclk);
    #1;
  endtask

  task automatic idle();
    s_tvalid = 1'b0;
    s_tdata  = '0;
  endtask

  task automatic cycles(input int k);
    repeat (k) @(posedge aclk);
    #1;
  endtask

  // Any wide handshake pops the scoreboard; sampled at the falling edge before it happens.
  always @(negedge aclk) begin
    exp_t e;
    if (aresetn && m_tvalid && m_tready) begin
      chk("sb_has_entry", 64'(sb.size() != 0), 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("m_tdata", m_tdata, e.data);
        chk("m_tcnt", m_tcnt, e.cnt);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    aresetn  = 1'b0;
    s_tvalid = 1'b0;
    s_tdata  = '0;
    m_tready = 1'b0;
    flush    = 1'b0;
    #12;
    chk("rst_m_tvalid", m_tvalid, 0);
    chk("rst_s_tready", s_tready, 0);
    chk("rst_m_tdata", m_tdata, 0);
    chk("rst_m_tcnt", m_tcnt, 0);
    chk("rst_pending", pending, 0);
    cycles(2);
    aresetn = 1'b1;
    cycles(1);

    // Back-to-back packing at full throughput
    m_tready = 1'b1;
    push_exp(32'h44332211, 3'd4);
    push_exp(32'h88776655, 3'd4);
    for (int i = 1; i <= 8; i++) begin
      send(8'(i * 8'h11), w);
      chk("t1_no_stall", 64'(w), 0);
      if (i == 4) chk("t1_latency", m_tvalid, 1);
    end
    idle();
    cycles(3);
    chk("t1_drained", m_tvalid, 0);

    // Output stalled: word held and slave side throttled
    m_tready = 1'b0;
    push_exp(32'h04030201, 3'd4);
    push_exp(32'h08070605, 3'd4);
    for (int i = 1; i <= 7; i++) send(8'(i), w);
    chk("t2_s_tready_low", s_tready, 0);
    idle();
    cycles(2);
    chk("t2_hold_valid", m_tvalid, 1);
    chk("t2_hold_data", m_tdata, 32'h04030201);
    chk("t2_hold_cnt", m_tcnt, 4);
    chk("t2_pending", pending, 1);
    m_tready = 1'b1;
    send(8'h08, w);
    chk("t2_beat8_no_stall", 64'(w), 0);
    chk("t2_second_valid", m_tvalid, 1);
    idle();
    cycles(3);

    // Flush with a two-lane partial word
    push_exp(32'h0000A2A1, 3'd2);
    send(8'hA1, w);
    send(8'hA2, w);
    idle();
    chk("t3_pending_before", pending, 1);
    flush = 1'b1;
    cycles(1);
    flush = 1'b0;
    chk("t3_pending_after", pending, 0);
    chk("t3_valid", m_tvalid, 1);
    cycles(3);

    // Flush coinciding with a beat, then flush with nothing accumulated
    push_exp(32'h00B3B2B1, 3'd3);
    send(8'hB1, w);
    send(8'hB2, w);
    flush = 1'b1;
    send(8'hB3, w);
    flush = 1'b0;
    idle();
    chk("t4_pending", pending, 0);
    chk("t4_valid", m_tvalid, 1);
    cycles(2);
    flush = 1'b1;
    repeat (3) begin
      cycles(1);
      chk("t4_empty_flush", m_tvalid, 0);
    end
    flush = 1'b0;
    cycles(1);

    // Flush held while the output register is stalled
    m_tready = 1'b0;
    push_exp(32'hC4C3C2C1, 3'd4);
    push_exp(32'h0000C6C5, 3'd2);
    for (int i = 1; i <= 6; i++) send(8'(8'hC0 + i), w);
    idle();
    flush = 1'b1;
    cycles(3);
    chk("t5_hold_data", m_tdata, 32'hC4C3C2C1);
    chk("t5_pending", pending, 1);
    m_tready = 1'b1;
    cycles(1);
    chk("t5_flush_cnt", m_tcnt, 2);
    chk("t5_pending_after", pending, 0);
    cycles(3);
    flush = 1'b0;
    chk("t5_idle", m_tvalid, 0);

    // Reset mid-packet discards the partial word
    send(8'hD1, w);
    send(8'hD2, w);
    idle();
    aresetn = 1'b0;
    #1;
    chk("t6_rst_s_tready", s_tready, 0);
    chk("t6_rst_pending", pending, 0);
    chk("t6_rst_valid", m_tvalid, 0);
    cycles(2);
    aresetn = 1'b1;
    repeat (3) begin
      cycles(1);
      chk("t6_post_rst_valid", m_tvalid, 0);
    end
    push_exp(32'hE4E3E2E1, 3'd4);
    for (int i = 1; i <= 4; i++) send(8'(8'hE0 + i), w);
    idle();
    cycles(4);

    chk("sb_empty", 64'(sb.size()), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/axis_upsizer.md
Name: axis_upsizer

Overview:
- AXI4-Stream width upsizer. Packs RATIO consecutive narrow beats into one wide beat.
- Sits directly upstream of the stream FIFO, so a narrow producer can feed the FIFO's wide write port at full throughput.
- Level-sensitive flush forces out a partially filled word, zero-padded, with a lane count.

Parameters:
- IN_WIDTH, 8: slave-side tdata width in bits.
- RATIO, 4: narrow beats per wide beat; power of two, >= 2.
- OUT_WIDTH, IN_WIDTH*RATIO: master-side tdata width; derived, never overridden.
- CNT_W, $clog2(RATIO)+1: width of m_tcnt.

Ports:
- aclk  in  1  clock; all logic on rising edge.
- aresetn  in  1  asynchronous active-low reset.
- s_tvalid  in  1  narrow beat valid.
- s_tready  out  1  narrow beat ready.
- s_tdata  in  IN_WIDTH  narrow beat data.
- m_tvalid  out  1  wide beat valid.
- m_tready  in  1  wide beat ready.
- m_tdata  out  OUT_WIDTH  wide beat data; lane k = bits [k*IN_WIDTH +: IN_WIDTH].
- m_tcnt  out  CNT_W  number of valid lanes in m_tdata, 1..RATIO.
- flush  in  1  level request to emit a partial word.
- pending  out  1  high when the accumulator holds 1..RATIO-1 beats (idx != 0).

Behaviour:
- State:
  - accumulator acc[OUT_WIDTH];
  - lane index idx (0..RATIO-1);
  - output register out_data / out_cnt / out_valid.
  - m_tvalid, m_tdata and m_tcnt are driven directly from the output register.
- Reset (aresetn low, asynchronous):
  - acc = 0, idx = 0, m_tvalid = 0, m_tdata = 0, m_tcnt = 0, pending = 0.
  - s_tready is forced to 0 while aresetn is low.
  - Reset mid-packet discards all partial and held data; no beat is emitted after release.
- Definitions:
  - out_free = !m_tvalid || m_tready.
  - s_hs = s_tvalid && s_tready.
  - m_hs = m_tvalid && m_tready.
- s_tready = aresetn && ((idx != RATIO-1) || out_free).
  - This is a combinational path from m_tready, and is intended.
- Packing: first accepted beat goes to lane 0 (LSBs), ascending.
  - On s_hs, acc lane idx <= s_tdata and idx increments.
- Completion: s_hs with idx == RATIO-1:
  - output register loads acc with lane RATIO-1 replaced by s_tdata; m_tcnt = RATIO; m_tvalid = 1 next cycle;
  - acc <= 0, idx <= 0.
  - Latency: last narrow beat accepted in cycle N gives m_tvalid high in cycle N+1.
  - Sustained s_tvalid and m_tready give 1 wide beat per RATIO cycles with no bubbles on the slave side.
- Flush: evaluated each cycle when flush = 1 and no completion occurs this cycle.
  - Let n = idx + (s_hs ? 1 : 0).
  - If n > 0 and out_free: the output register loads acc, including this cycle's beat in lane idx; unused lanes are 0; m_tcnt = n; acc <= 0, idx <= 0.
  - If n > 0 and not out_free: the beat, if any, is accumulated normally and the flush is retried on later cycles while flush stays high.
  - If n == 0: no action. No empty beats are ever emitted.
  - Flush coinciding with a completion: the completion takes precedence; the flush then sees idx = 0 and does nothing.
- Output hold: while m_tvalid && !m_tready, m_tdata and m_tcnt are stable (AXI4-Stream rule).
  - m_tvalid deasserts only after m_hs with no new load in the same cycle.
  - m_hs and a new load in the same cycle keep m_tvalid = 1 with the new data.
- No combinational path exists from s_tvalid or s_tdata to any m_* output.
- pending = (idx != 0), registered state.

Test Plan:
- Reset then 8 beats 0x11..0x88, m_tready = 1 → two wide beats: 0x44332211 (cnt 4) one cycle after 0x44 is accepted, then 0x88776655 (cnt 4); s_tready stays high throughout.
- m_tready = 0, feed 7 beats 0x01..0x07 → 0x04030201 held on m_tdata; s_tready drops when idx = 3 with the output full; raise m_tready → 0x04030201 then 0x08070605 after beat 0x08.
- Feed 0xA1, 0xA2, then flush = 1 for one cycle → m_tdata = 0x0000A2A1, m_tcnt = 2, pending low the cycle after.
- flush = 1 in the same cycle as s_hs of 0xB3 with idx = 2 (lanes 0xB1, 0xB2) → 0x00B3B2B1, m_tcnt = 3; flush with idx = 0 and no beat → no m_tvalid.
- Flush while the output is stalled (m_tready = 0), flush held high → the partial word is emitted on the first cycle after the output drains, with correct count.
- Assert aresetn low after 2 of 4 beats, release, feed 4 new beats → only the 4 new beats appear as one word; m_tvalid stays 0 during and after reset until then.
